// File: rtl/atmega_tim_pkg.sv
// -----------------------------------------------------------------------------
// atmega_tim_pkg
// Shared definitions for the ATmega-style timer clock-source block:
//   - clock-select encodings (TCCRB[2:0] of the downstream timer)
//   - GTCCR bit positions
//   - prescaler width and a helper that decodes the prescaler tap for a
//     given clock-select value
// -----------------------------------------------------------------------------
package atmega_tim_pkg;

  // Clock-select encodings as seen on the cs input.
  typedef enum logic [2:0] {
    CS_STOP     = 3'd0,
    CS_CLK1     = 3'd1,
    CS_CLK8     = 3'd2,
    CS_CLK64    = 3'd3,
    CS_CLK256   = 3'd4,
    CS_CLK1024  = 3'd5,
    CS_EXT_FALL = 3'd6,
    CS_EXT_RISE = 3'd7
  } cs_e;

  // GTCCR bit indices.
  localparam int GTCCR_TSM     = 7;
  localparam int GTCCR_PSRSYNC = 0;

  // Prescaler counter width.
  localparam int PSC_W = 10;

  // Returns 1 when the prescaler sits on the last count of the period
  // selected by sel. Only the divided settings (cs 2..5) have a tap; every
  // other encoding returns 0 so the caller decides their behaviour.
  function automatic logic prescale_tap(input logic [2:0] sel,
                                        input logic [PSC_W-1:0] cnt);
    logic hit;
    hit = 1'b0;
    case (sel)
      CS_CLK8:    hit = (cnt[2:0] == 3'h7);
      CS_CLK64:   hit = (cnt[5:0] == 6'h3f);
      CS_CLK256:  hit = (cnt[7:0] == 8'hff);
      CS_CLK1024: hit = (cnt[9:0] == 10'h3ff);
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  // True for the clock-select values that draw from the shared prescaler.
  function automatic logic is_prescaled(input logic [2:0] sel);
    return (sel == CS_CLK8) || (sel == CS_CLK64) ||
           (sel == CS_CLK256) || (sel == CS_CLK1024);
  endfunction

endpackage

// File: rtl/atmega_tim_ext_sync.sv
// -----------------------------------------------------------------------------
// atmega_tim_ext_sync
// Brings the asynchronous external clock pin into the clk domain through a
// two-flop synchroniser (s1, s2) and keeps the previous synchronised value
// in s3 so that rising/falling edges can be detected as s2 vs s3.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-low reset (clears s1..s3)
//   t     in   external clock pin, asynchronous to clk
//   rise  out  combinational: synchronised t went 0->1
//   fall  out  combinational: synchronised t went 1->0
// -----------------------------------------------------------------------------
module atmega_tim_ext_sync (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability; s3 holds the previous s2 for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= t;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/atmega_tim_clk_src.sv
// -----------------------------------------------------------------------------
// atmega_tim_clk_src
// Clock-source / prescaler front end for an ATmega-style 8-bit timer.
// A 10-bit free-running prescaler is shared by all clock selections; the cs
// input picks a tap (or the external pin) and the selected enable is
// registered into a single-cycle tick for the downstream timer. GTCCR holds
// TSM (bit 7) and PSRSYNC (bit 0) for synchronised prescaler reset.
//
// Optional feature: define ATMEGA_TIM_EXT_CLK_EN to build the external clock
// path (cs 6/7, t pin synchroniser). Without it cs 6/7 produce no ticks and
// t is ignored.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   addr_io     in   IO bus address [BUS_ADDR_IO_LEN-1:0]
//   wr_io       in   IO write strobe
//   rd_io       in   IO read strobe
//   bus_io_in   in   IO write data [7:0]
//   bus_io_out  out  IO read data [7:0]; 0 when GTCCR not being read
//   cs          in   clock select [2:0] (TCCRB[2:0] of the timer)
//   t           in   external clock pin, asynchronous
//   tick        out  one-clk count enable to the timer
//   psr_active  out  high while the prescaler is held in reset (PSRSYNC)
// -----------------------------------------------------------------------------
module atmega_tim_clk_src
  import atmega_tim_pkg::*;
#(
  parameter int unsigned BUS_ADDR_IO_LEN = 6,
  parameter int unsigned GTCCR_ADDR      = 'h23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr_io,
  input  logic                       wr_io,
  input  logic                       rd_io,
  input  logic [7:0]                 bus_io_in,
  output logic [7:0]                 bus_io_out,
  input  logic [2:0]                 cs,
  input  logic                       t,
  output logic                       tick,
  output logic                       psr_active
);

  localparam logic [BUS_ADDR_IO_LEN-1:0] GTCCR_SEL =
    GTCCR_ADDR[BUS_ADDR_IO_LEN-1:0];

  logic [PSC_W-1:0] cnt;
  logic             tsm;
  logic             psrsync;
  logic             gtccr_hit;
  logic             gtccr_wr;
  logic             gtccr_rd;
  logic             ext_rise;
  logic             ext_fall;
  logic             raw_en_p0;
  logic             tick_p1;

  // Write-only bits of GTCCR that have no storage.
  logic unused_wdata;
  assign unused_wdata = ^bus_io_in[6:1];

  assign gtccr_hit = (addr_io == GTCCR_SEL);
  assign gtccr_wr  = wr_io && gtccr_hit;
  assign gtccr_rd  = rd_io && gtccr_hit;

  // ---------------------------------------------------------------------------
  // GTCCR register.
  // A bus write takes priority. Otherwise PSRSYNC self-clears whenever TSM is
  // low, so a single write of PSRSYNC=1 with TSM=0 yields exactly one clear
  // cycle, and writing TSM=0 releases a held PSRSYNC on the next clk.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tsm     <= 1'b0;
      psrsync <= 1'b0;
    end else if (gtccr_wr) begin
      tsm     <= bus_io_in[GTCCR_TSM];
      psrsync <= bus_io_in[GTCCR_PSRSYNC];
    end else if (!tsm) begin
      psrsync <= 1'b0;
    end
  end

  assign psr_active = psrsync;

  always_comb begin
    bus_io_out = 8'h00;
    if (gtccr_rd) begin
      bus_io_out                = 8'h00;
      bus_io_out[GTCCR_TSM]     = tsm;
      bus_io_out[GTCCR_PSRSYNC] = psrsync;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler: counts every clk independent of cs, wraps naturally at
  // 1023->0, and is forced to 0 for every cycle PSRSYNC is set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (psrsync) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // External clock path.
  // ---------------------------------------------------------------------------
`ifdef ATMEGA_TIM_EXT_CLK_EN
  atmega_tim_ext_sync u_ext_sync (
    .clk  (clk),
    .rst  (rst),
    .t    (t),
    .rise (ext_rise),
    .fall (ext_fall)
  );
`else
  logic unused_t;
  assign unused_t = t;
  assign ext_rise = 1'b0;
  assign ext_fall = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage p0: raw enable selection. Prescaled taps are masked while the
  // prescaler is held so a stale count cannot leak a tick; cs 1 and the
  // external edges ignore PSRSYNC. cs is used directly, so a cs change only
  // re-points the selection and never creates a pulse by itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    raw_en_p0 = 1'b0;
    case (cs)
      CS_CLK1:     raw_en_p0 = 1'b1;
      CS_EXT_FALL: raw_en_p0 = ext_fall;
      CS_EXT_RISE: raw_en_p0 = ext_rise;
      default:     raw_en_p0 = is_prescaled(cs) && prescale_tap(cs, cnt) &&
                               !psrsync;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered tick, one clk wide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= raw_en_p0;
    end
  end

  assign tick = tick_p1;

endmodule

// File: tb/tb_atmega_tim_clk_src.sv
// -----------------------------------------------------------------------------
// tb_atmega_tim_clk_src
// Directed testbench for atmega_tim_clk_src. Inputs change 1 time unit after
// a rising clk edge; outputs are sampled at the same point, so "edge n" below
// means the n-th rising edge after reset release.
// -----------------------------------------------------------------------------
module tb_atmega_tim_clk_src;

  localparam int AW = 6;
  localparam logic [AW-1:0] GTCCR_A = 6'h23;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr_io;
  logic          wr_io;
  logic          rd_io;
  logic [7:0]    bus_io_in;
  logic [7:0]    bus_io_out;
  logic [2:0]    cs;
  logic          t;
  logic          tick;
  logic          psr_active;

  int n_cmp;
  int n_bad;

  atmega_tim_clk_src #(
    .BUS_ADDR_IO_LEN (AW),
    .GTCCR_ADDR      ('h23)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_io    (addr_io),
    .wr_io      (wr_io),
    .rd_io      (rd_io),
    .bus_io_in  (bus_io_in),
    .bus_io_out (bus_io_out),
    .cs         (cs),
    .t          (t),
    .tick       (tick),
    .psr_active (psr_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] cs_val);
    rst       = 1'b0;
    wr_io     = 1'b0;
    rd_io     = 1'b0;
    addr_io   = '0;
    bus_io_in = 8'h00;
    t         = 1'b0;
    cs        = cs_val;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic gtccr_write(input logic [7:0] d);
    addr_io   = GTCCR_A;
    bus_io_in = d;
    wr_io     = 1'b1;
    step();
    wr_io     = 1'b0;
    bus_io_in = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_io = 1'b0; cs = 3'd1; t = 1'b0; bus_io_in = 8'h00;
    rd_io = 1'b1; addr_io = GTCCR_A;
    #3;
    n_cmp++;
    if (tick !== 1'b0) begin
      n_bad++; $display("FAIL reset_tick got=%b exp=0", tick);
    end
    n_cmp++;
    if (psr_active !== 1'b0) begin
      n_bad++; $display("FAIL reset_psr got=%b exp=0", psr_active);
    end
    n_cmp++;
    if (bus_io_out !== 8'h00) begin
      n_bad++; $display("FAIL reset_rd got=%h exp=00", bus_io_out);
    end
    step();
    rst = 1'b1;
    // cs=1 gives a tick on the very first edge after release.
    step();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++; $display("FAIL release_tick got=%b exp=1", tick);
    end
    addr_io = 6'h22;
    #1;
    n_cmp++;
    if (bus_io_out !== 8'h00) begin
      n_bad++; $display("FAIL rd_wrong_addr got=%h exp=00", bus_io_out);
    end
    rd_io = 1'b0;
  endtask

  task automatic test_div8();
    do_reset(3'd2);
    for (int n = 1; n <= 88; n++) begin
      step();
      n_cmp++;
      if (tick !== (n % 8 == 0)) begin
        n_bad++; $display("FAIL div8 edge=%0d got=%b exp=%b", n, tick, (n % 8 == 0));
      end
    end
  endtask

  task automatic test_div1024();
    do_reset(3'd5);
    for (int n = 1; n <= 2100; n++) begin
      step();
      n_cmp++;
      if (tick !== (n % 1024 == 0)) begin
        n_bad++; $display("FAIL div1024 edge=%0d got=%b exp=%b", n, tick, (n % 1024 == 0));
      end
    end
  endtask

  task automatic test_div1_and_stop();
    do_reset(3'd1);
    for (int n = 1; n <= 20; n++) begin
      step();
      n_cmp++;
      if (tick !== 1'b1) begin
        n_bad++; $display("FAIL div1 edge=%0d got=%b exp=1", n, tick);
      end
    end
    // cs=0 stops ticks; prescaler keeps running underneath.
    do_reset(3'd0);
    for (int n = 1; n <= 5; n++) begin
      step();
      n_cmp++;
      if (tick !== 1'b0) begin
        n_bad++; $display("FAIL stop edge=%0d got=%b exp=0", n, tick);
      end
    end
    // Prescaler is at 5; switch to /8 -> ticks on edges 8 and 16 only.
    cs = 3'd2;
    for (int n = 6; n <= 20; n++) begin
      step();
      n_cmp++;
      if (tick !== (n % 8 == 0)) begin
        n_bad++; $display("FAIL cs_switch edge=%0d got=%b exp=%b", n, tick, (n % 8 == 0));
      end
    end
  endtask

  task automatic test_psr_clear();
    do_reset(3'd3);
    repeat (20) step();
    gtccr_write(8'h01);
    rd_io = 1'b1; addr_io = GTCCR_A;
    #1;
    n_cmp++;
    if (bus_io_out !== 8'h01) begin
      n_bad++; $display("FAIL psr_rd1 got=%h exp=01", bus_io_out);
    end
    n_cmp++;
    if (psr_active !== 1'b1) begin
      n_bad++; $display("FAIL psr_active1 got=%b exp=1", psr_active);
    end
    step();
    n_cmp++;
    if (bus_io_out !== 8'h00) begin
      n_bad++; $display("FAIL psr_rd2 got=%h exp=00", bus_io_out);
    end
    n_cmp++;
    if (psr_active !== 1'b0) begin
      n_bad++; $display("FAIL psr_active2 got=%b exp=0", psr_active);
    end
    rd_io = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      step();
      n_cmp++;
      if (tick !== (k % 64 == 0)) begin
        n_bad++; $display("FAIL psr_div64 k=%0d got=%b exp=%b", k, tick, (k % 64 == 0));
      end
    end
  endtask

  task automatic test_tsm_hold();
    int bad_ticks;
    do_reset(3'd4);
    gtccr_write(8'h81);
    bad_ticks = 0;
    for (int k = 1; k <= 500; k++) begin
      step();
      if (tick !== 1'b0 || psr_active !== 1'b1) bad_ticks++;
    end
    n_cmp++;
    if (bad_ticks != 0) begin
      n_bad++; $display("FAIL tsm_hold bad_cycles=%0d exp=0", bad_ticks);
    end
    rd_io = 1'b1; addr_io = GTCCR_A;
    #1;
    n_cmp++;
    if (bus_io_out !== 8'h81) begin
      n_bad++; $display("FAIL tsm_rd got=%h exp=81", bus_io_out);
    end
    rd_io = 1'b0;
    gtccr_write(8'h00);
    n_cmp++;
    if (psr_active !== 1'b0) begin
      n_bad++; $display("FAIL tsm_release_psr got=%b exp=0", psr_active);
    end
    for (int k = 1; k <= 300; k++) begin
      step();
      n_cmp++;
      if (tick !== (k == 256)) begin
        n_bad++; $display("FAIL tsm_resume k=%0d got=%b exp=%b", k, tick, (k == 256));
      end
    end
  endtask

  task automatic ext_phase(input logic [2:0] cs_val, input logic t_val,
                           input int tick_at, input string name);
    cs = cs_val;
    t  = t_val;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_cmp++;
      if (tick !== (k == tick_at)) begin
        n_bad++; $display("FAIL %s k=%0d got=%b exp=%b", name, k, tick, (k == tick_at));
      end
    end
  endtask

  task automatic test_ext_clk();
    do_reset(3'd7);
    repeat (3) step();
`ifdef ATMEGA_TIM_EXT_CLK_EN
    ext_phase(3'd7, 1'b1, 3, "ext_rise_up");
    ext_phase(3'd7, 1'b0, 0, "ext_rise_dn");
    ext_phase(3'd6, 1'b1, 0, "ext_fall_up");
    ext_phase(3'd6, 1'b0, 3, "ext_fall_dn");
`else
    ext_phase(3'd7, 1'b1, 0, "noext_rise_up");
    ext_phase(3'd7, 1'b0, 0, "noext_rise_dn");
    ext_phase(3'd6, 1'b1, 0, "noext_fall_up");
    ext_phase(3'd6, 1'b0, 0, "noext_fall_dn");
`endif
  endtask

  task automatic test_reset_mid();
    do_reset(3'd2);
    gtccr_write(8'h80);
    repeat (6) step();
    step();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre_tick got=%b exp=1", tick);
    end
    rd_io = 1'b1; addr_io = GTCCR_A;
    #1;
    n_cmp++;
    if (bus_io_out !== 8'h80) begin
      n_bad++; $display("FAIL mid_pre_rd got=%h exp=80", bus_io_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tick !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst_tick got=%b exp=0", tick);
    end
    n_cmp++;
    if (bus_io_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_rst_rd got=%h exp=00", bus_io_out);
    end
    step();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_io_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_post_rd got=%h exp=00", bus_io_out);
    end
    rd_io = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++;
      if (tick !== (k == 8)) begin
        n_bad++; $display("FAIL mid_restart k=%0d got=%b exp=%b", k, tick, (k == 8));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; addr_io = '0; wr_io = 1'b0; rd_io = 1'b0;
    bus_io_in = 8'h00; cs = 3'd0; t = 1'b0;
    test_reset();
    test_div8();
    test_div1024();
    test_div1_and_stop();
    test_psr_clear();
    test_tsm_hold();
    test_ext_clk();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
